// File: rtl/asip_isa_pkg.sv
// Shared definitions for the 16-bit vector ASIP instruction format.
// Defines the field widths and bit positions, the named opcodes, the encoder
// FSM states, and a helper that packs the fields into one instruction word.
package asip_isa_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned INSTR_W = OPC_W + REG_W + IMM_W;

  // MSB of each field inside the instruction word.
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned REG_MSB = 11;
  localparam int unsigned IMM_MSB = 7;

  localparam logic [OPC_W-1:0] OPC_LOSC  = 4'b0000;  // load scalar from immediate
  localparam logic [OPC_W-1:0] OPC_SUPIX = 4'b1100;  // store pixel

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } enc_state_t;

  // Plain field concatenation. Field contents are not checked, so every
  // opcode, including the named ones, is encoded the same way.
  function automatic logic [INSTR_W-1:0] encode_instr(input logic [OPC_W-1:0] opc,
                                                      input logic [REG_W-1:0] rg,
                                                      input logic [IMM_W-1:0] imm);
    logic [INSTR_W-1:0] word;
    word = '0;
    word[OPC_MSB -: OPC_W] = opc;
    word[REG_MSB -: REG_W] = rg;
    word[IMM_MSB -: IMM_W] = imm;
    return word;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO that buffers encoded instruction words.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   push, wdata   write request and data (ignored when full)
//   pop           read request (ignored when empty); rdata shows the head
//   full, empty   occupancy flags
// DEPTH must be a power of two, at least 2. Push and pop may happen together.
module instr_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Program-load engine: packs {opcode, reg, imm} field sets into 16-bit
// instruction words, buffers them, and writes them to instruction memory at
// consecutive addresses starting at a base latched on start.
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   start, base_addr          begin a session (IDLE only) at base_addr
//   op_valid/op_ready         field-set handshake; op_opcode/op_reg/op_imm fields
//   op_last                   final instruction of the program
//   imem_stall                memory cannot take a new write this cycle
//   imem_we/addr/wdata        registered instruction memory write port
//   busy, done                not IDLE; one-cycle end-of-session pulse
//   overflow                  sticky: program truncated at the last address
//   word_count                words accepted in the current session
module instr_stream_encoder
  import asip_isa_pkg::*;
#(
  parameter int unsigned N          = 16,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_opcode,
  input  logic [3:0]        op_reg,
  input  logic [7:0]        op_imm,
  input  logic              op_last,
  input  logic              imem_stall,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [N-1:0]      imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  enc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [N-1:0]      imem_wdata_q, imem_wdata_d;
  logic              imem_we_q, imem_we_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;

  logic              handshake;
  logic              at_last_addr;
  logic              drain_done;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [N-1:0]      fifo_rdata;
  logic [N-1:0]      enc_word;

  assign enc_word     = N'(encode_instr(op_opcode, op_reg, op_imm));
  assign handshake    = op_valid && op_ready;
  assign at_last_addr = (acc_addr_q == LastAddr);
  // The write presented this cycle is always taken, so once it has been
  // presented and the buffer is empty nothing is left in flight.
  assign drain_done   = fifo_empty && !imem_we_q;
  // The writer runs whenever a session is active (LOAD or DRAIN).
  assign fifo_pop     = (state_q != IDLE) && !fifo_empty && !imem_stall;

  instr_fifo #(
    .WIDTH (N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (handshake),
    .wdata (enc_word),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      // Accepting a word at the last address ends the program with or without op_last.
      LOAD:    if (handshake && (op_last || at_last_addr)) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. op_ready ignores a same-cycle pop when the buffer is full.
  always_comb begin
    op_ready = (state_q == LOAD) && !fifo_full;
    busy     = (state_q != IDLE);
    done     = (state_q == DRAIN) && drain_done;
  end

  // Datapath next state.
  always_comb begin
    acc_addr_d   = acc_addr_q;
    wr_addr_d    = wr_addr_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    imem_we_d    = 1'b0;
    overflow_d   = overflow_q;
    word_count_d = word_count_q;

    if ((state_q == IDLE) && start) begin
      acc_addr_d   = base_addr;
      wr_addr_d    = base_addr;
      word_count_d = '0;
      overflow_d   = 1'b0;
    end

    if (handshake) begin
      acc_addr_d   = acc_addr_q + ADDR_W'(1);
      word_count_d = word_count_q + (ADDR_W+1)'(1);
      if (!op_last && at_last_addr) overflow_d = 1'b1;
    end

    if (fifo_pop) begin
      imem_we_d    = 1'b1;
      imem_addr_d  = wr_addr_q;
      imem_wdata_d = fifo_rdata;
      wr_addr_d    = wr_addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_addr_q   <= '0;
      wr_addr_q    <= '0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      imem_we_q    <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      acc_addr_q   <= acc_addr_d;
      wr_addr_q    <= wr_addr_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      imem_we_q    <= imem_we_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule

// File: doc/instr_stream_encoder.md
Name: instr_stream_encoder

Overview:
Program-load engine for the vector ASIP, and the write side of the 16-bit instruction format the decode stage consumes.
- Accepts instruction fields (opcode, register, immediate) over a valid/ready handshake.
- Packs each set into the 16-bit instruction word and buffers it in a small FIFO.
- Writes the words into instruction memory at consecutive addresses from a programmable base.
- Sits between the host/boot loader and the instruction memory write port.

Parameters:
N, 16, instruction width; must equal 4+4+8.
ADDR_W, 8, instruction memory address width; last address is 2^ADDR_W-1.
FIFO_DEPTH, 4, encoded-word buffer depth (power of two, at least 2).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset: synchronous, active-high
start  in  1  begin a load session; honoured in IDLE only
base_addr  in  ADDR_W  first write address, latched on start
op_valid  in  1  field set valid
op_ready  out  1  encoder can accept a field set
op_opcode  in  4  opcode field, placed in word[15:12]
op_reg  in  4  register field, placed in word[11:8]
op_imm  in  8  immediate field, placed in word[7:0]
op_last  in  1  marks the final instruction of the program
imem_stall  in  1  memory cannot take a new write this cycle
imem_we  out  1  instruction memory write enable
imem_addr  out  ADDR_W  write address
imem_wdata  out  N  encoded instruction
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse when the session completes
overflow  out  1  sticky; program truncated at the end of memory
word_count  out  ADDR_W+1  words accepted in the current session

Behaviour:
Reset:
- State is IDLE and the FIFO is empty.
- imem_we=0, imem_addr=0, imem_wdata=0, op_ready=0, busy=0, done=0, overflow=0, word_count=0.
- Reset mid-session discards all buffered words; no imem_we is asserted in the cycle after reset.

States:
- IDLE: on start=1, latch base_addr into both acc_addr and wr_addr, clear word_count and overflow, go to LOAD.
- LOAD:
  - op_ready = !fifo_full. A handshake (op_valid & op_ready) pushes {op_opcode, op_reg, op_imm}, increments acc_addr and word_count.
  - Handshake with op_last=1: go to DRAIN.
  - Handshake with op_last=0 while acc_addr = 2^ADDR_W-1: the word is accepted, overflow<=1, go to DRAIN. No wrap to address 0.
  - A word with op_last=1 at the last address is legal and does not set overflow.
- DRAIN: op_ready=0. When the FIFO is empty and no write is in flight, pulse done for 1 cycle and go to IDLE.
- start is ignored outside IDLE.
- op_* inputs are ignored when op_ready=0.
- op_valid may rise or fall freely; there is no hold requirement on the source.

Encoding:
- Pure bit concatenation; no field checking.
- Opcode 0000 (load scalar from immediate) and 1100 (store pixel) are encoded like any other opcode.

Writer (LOAD and DRAIN):
- Each cycle with the FIFO non-empty and imem_stall=0: pop the head and register imem_we=1, imem_addr=wr_addr, imem_wdata=head; then wr_addr++.
- Otherwise imem_we<=0. imem_addr and imem_wdata hold their last value.
- A presented write is always taken by memory; stall only blocks issuing the next write.

Latency:
- A handshake at edge k into an empty FIFO with no stall gives imem_we=1 after edge k+1.
- Sustained throughput is 1 word/cycle.

FIFO:
- A simultaneous push and pop is allowed when the FIFO is not full.
- When full, op_ready=0 even if a pop occurs in the same cycle.

Decomposition:
- Package asip_isa_pkg:
  - field widths and slice positions (OPC_MSB=15, REG_MSB=11, IMM_MSB=7);
  - opcode constants OPC_LOSC=4'b0000 and OPC_SUPIX=4'b1100;
  - enum enc_state_t {IDLE, LOAD, DRAIN}.
- Sub-module instr_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty, same clk and rst.

Test Plan:
- Basic load: start with base_addr=8'h10, then 3 words (opcode 1100/reg 5/imm 8'hA3, then 0000/2/8'h7F, then 1001/4/8'h00 with op_last=1), no stall.
  -> writes 16'hC5A3@10, 16'h027F@11, 16'h9400@12, 1 cycle apart; done pulses once; word_count=3.
- Back-pressure: imem_stall=1 for 6 cycles while op_valid is held.
  -> exactly FIFO_DEPTH=4 words accepted and op_ready=0; after the stall drops, 4 consecutive writes in order with no loss or duplication.
- End of memory: base_addr=8'hFE, 3 words, op_last only on the third.
  -> writes at FE and FF only; overflow=1; third word not accepted; done pulses.
- Legal edge case: base_addr=8'hFF, single word with op_last=1.
  -> one write at FF; overflow=0.
- Reset mid-session: assert rst while the FIFO holds 2 words.
  -> imem_we=0 the next cycle; all outputs at reset values; a subsequent start begins cleanly at the new base_addr.
- start asserted during LOAD with a different base_addr.
  -> ignored; addresses continue from the original base.
